lockstep_commit_checker: RTL and testbench

//  Parametrised successor to the single-issue OOO-vs-ISA equivalence harness. Buffers up to

---
 rtl/lockstep_commit_checker.sv | 210 +++++++++++++++++++++
 tb/tb_lockstep_commit_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_commit_checker.sv
// Buffers in-order DUT commit groups and single-steps an ISA reference once per record,
// comparing each retired instruction and latching the first failure cause.
module lockstep_commit_checker #(
  parameter int PC_W       = 3,
  parameter int RD_W       = 2,
  parameter int DATA_W     = 8,
  parameter int COMMIT_W   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_same,
  input  logic [COMMIT_W-1:0]        dut_commit_valid,
  input  logic [COMMIT_W*PC_W-1:0]   dut_commit_pc,
  input  logic [COMMIT_W*RD_W-1:0]   dut_commit_rd,
  input  logic [COMMIT_W-1:0]        dut_commit_wen,
  input  logic [COMMIT_W*DATA_W-1:0] dut_commit_wdata,
  output logic                       dut_ready,
  output logic                       ref_step,
  input  logic                       ref_valid,
  input  logic [PC_W-1:0]            ref_pc,
  input  logic [RD_W-1:0]            ref_rd,
  input  logic                       ref_wen,
  input  logic [DATA_W-1:0]          ref_wdata,
  output logic                       incorrect,
  output logic [2:0]                 fail_code,
  output logic [PC_W-1:0]            mismatch_pc,
  output logic [CNT_W-1:0]           match_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MEM_N = 1 << PTR_W;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] FC_INIT     = 3'b001;
  localparam logic [2:0] FC_MISMATCH = 3'b010;
  localparam logic [2:0] FC_PROTO    = 3'b011;
  localparam logic [2:0] FC_TIMEOUT  = 3'b100;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAIL} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              outstanding_q, outstanding_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              incorrect_q, incorrect_d;
  logic [2:0]        fail_code_q, fail_code_d;
  logic [PC_W-1:0]   mismatch_pc_q, mismatch_pc_d;
  logic [CNT_W-1:0]  match_count_q, match_count_d;

  logic [PC_W-1:0]   pc_mem    [MEM_N];
  logic [RD_W-1:0]   rd_mem    [MEM_N];
  logic              wen_mem   [MEM_N];
  logic [DATA_W-1:0] wdata_mem [MEM_N];

  logic [PC_W-1:0]   lane_pc    [COMMIT_W];
  logic [RD_W-1:0]   lane_rd    [COMMIT_W];
  logic              lane_wen   [COMMIT_W];
  logic [DATA_W-1:0] lane_wdata [COMMIT_W];

  for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_lane
    assign lane_pc[gi]    = dut_commit_pc[gi*PC_W +: PC_W];
    assign lane_rd[gi]    = dut_commit_rd[gi*RD_W +: RD_W];
    assign lane_wen[gi]   = dut_commit_wen[gi];
    assign lane_wdata[gi] = dut_commit_wdata[gi*DATA_W +: DATA_W];
  end

  logic                run;
  logic                any_valid;
  logic [COMMIT_W-1:0] valid_inc;
  logic                valid_contig;
  logic [CW-1:0]       push_n;
  logic                head_match;
  logic                proto_err;
  logic                mism;
  logic [WD_W-1:0]     wd_inc;
  logic                timeout_hit;
  logic                do_push;

  assign run       = (state_q == ST_RUN);
  assign dut_ready = run && ((CW'(FIFO_DEPTH) - count_q) >= CW'(COMMIT_W));
  // Only the oldest un-stepped record may be requested; at most one is ever in flight.
  assign ref_step  = run && (count_q > CW'(outstanding_q));

  assign incorrect   = incorrect_q;
  assign fail_code   = fail_code_q;
  assign mismatch_pc = mismatch_pc_q;
  assign match_count = match_count_q;

  assign any_valid    = |dut_commit_valid;
  assign valid_inc    = dut_commit_valid + COMMIT_W'(1);
  assign valid_contig = ((dut_commit_valid & valid_inc) == '0);

  assign head_match = (pc_mem[rd_ptr_q] == ref_pc) && (wen_mem[rd_ptr_q] == ref_wen) &&
                      (!wen_mem[rd_ptr_q] ||
                       ((rd_mem[rd_ptr_q] == ref_rd) && (wdata_mem[rd_ptr_q] == ref_wdata)));

  always_comb begin
    push_n = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      push_n = push_n + CW'(dut_commit_valid[i]);
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    wd_d          = wd_q;
    incorrect_d   = incorrect_q;
    fail_code_d   = fail_code_q;
    mismatch_pc_d = mismatch_pc_q;
    match_count_d = match_count_q;
    do_push       = 1'b0;

    // outstanding_q doubles as "ref_step was high last cycle" since ISA latency is fixed at 1.
    proto_err = (any_valid && (!dut_ready || !valid_contig)) || (ref_valid != outstanding_q);
    mism      = ref_valid && outstanding_q && !head_match;
    if (any_valid || (count_q != '0) || (TIMEOUT == 0)) begin
      wd_inc = '0;
    end else begin
      wd_inc = wd_q + WD_W'(1);
    end
    timeout_hit = (TIMEOUT != 0) && (wd_inc == WD_W'(TIMEOUT));

    case (state_q)
      ST_INIT: begin
        if (!init_same) begin
          state_d     = ST_FAIL;
          incorrect_d = 1'b1;
          fail_code_d = FC_INIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (proto_err) begin
          state_d     = ST_FAIL;
          incorrect_d = 1'b1;
          fail_code_d = FC_PROTO;
        end else if (mism) begin
          state_d       = ST_FAIL;
          incorrect_d   = 1'b1;
          fail_code_d   = FC_MISMATCH;
          mismatch_pc_d = pc_mem[rd_ptr_q];
        end else if (timeout_hit) begin
          state_d     = ST_FAIL;
          incorrect_d = 1'b1;
          fail_code_d = FC_TIMEOUT;
        end else begin
          do_push       = any_valid;
          wr_ptr_d      = wr_ptr_q + PTR_W'(push_n);
          rd_ptr_d      = rd_ptr_q + PTR_W'(ref_valid);
          count_d       = count_q + push_n - CW'(ref_valid);
          outstanding_d = ref_step;
          wd_d          = wd_inc;
          if (ref_valid && (match_count_q != '1)) begin
            match_count_d = match_count_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < COMMIT_W; i++) begin
      if (do_push && dut_commit_valid[i]) begin
        pc_mem[wr_ptr_q + PTR_W'(i)]    <= lane_pc[i];
        rd_mem[wr_ptr_q + PTR_W'(i)]    <= lane_rd[i];
        wen_mem[wr_ptr_q + PTR_W'(i)]   <= lane_wen[i];
        wdata_mem[wr_ptr_q + PTR_W'(i)] <= lane_wdata[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= 1'b0;
      wd_q          <= '0;
      incorrect_q   <= 1'b0;
      fail_code_q   <= '0;
      mismatch_pc_q <= '0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      wd_q          <= wd_d;
      incorrect_q   <= incorrect_d;
      fail_code_q   <= fail_code_d;
      mismatch_pc_q <= mismatch_pc_d;
      match_count_q <= match_count_d;
    end
  end

endmodule

// File: tb/tb_lockstep_commit_checker.sv
// Bench for lockstep_commit_checker: directed scenarios plus randomized commit traffic,
// checked every cycle against a queue-based reference model that also plays the ISA.
module tb_lockstep_commit_checker;
  localparam int PC_W = 3, RD_W = 2, DATA_W = 8, COMMIT_W = 2;
  localparam int FIFO_DEPTH = 4, TIMEOUT = 16, CNT_W = 16;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       init_same = 1'b0;
  logic [COMMIT_W-1:0]        dut_commit_valid = '0;
  logic [COMMIT_W*PC_W-1:0]   dut_commit_pc = '0;
  logic [COMMIT_W*RD_W-1:0]   dut_commit_rd = '0;
  logic [COMMIT_W-1:0]        dut_commit_wen = '0;
  logic [COMMIT_W*DATA_W-1:0] dut_commit_wdata = '0;
  logic                       dut_ready, ref_step;
  logic                       ref_valid = 1'b0;
  logic [PC_W-1:0]            ref_pc = '0;
  logic [RD_W-1:0]            ref_rd = '0;
  logic                       ref_wen = 1'b0;
  logic [DATA_W-1:0]          ref_wdata = '0;
  logic                       incorrect;
  logic [2:0]                 fail_code;
  logic [PC_W-1:0]            mismatch_pc;
  logic [CNT_W-1:0]           match_count;

  lockstep_commit_checker #(
    .PC_W(PC_W), .RD_W(RD_W), .DATA_W(DATA_W), .COMMIT_W(COMMIT_W),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .init_same(init_same),
    .dut_commit_valid(dut_commit_valid), .dut_commit_pc(dut_commit_pc),
    .dut_commit_rd(dut_commit_rd), .dut_commit_wen(dut_commit_wen),
    .dut_commit_wdata(dut_commit_wdata), .dut_ready(dut_ready), .ref_step(ref_step),
    .ref_valid(ref_valid), .ref_pc(ref_pc), .ref_rd(ref_rd), .ref_wen(ref_wen),
    .ref_wdata(ref_wdata), .incorrect(incorrect), .fail_code(fail_code),
    .mismatch_pc(mismatch_pc), .match_count(match_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [RD_W-1:0]   rd;
    logic              wen;
    logic [DATA_W-1:0] wdata;
  } rec_t;

  // Reference model: phase 0 init, 1 run, 2 failed.
  rec_t fifo_q[$];
  int   m_state, m_idle, m_code, m_mpc, m_cnt;
  bit   m_out, m_inc;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rec_eq(input rec_t r);
    return (r.pc == ref_pc) && (r.wen == ref_wen) &&
           (!r.wen || ((r.rd == ref_rd) && (r.wdata == ref_wdata)));
  endfunction

  function automatic bit exp_ready();
    return (m_state == 1) && ((FIFO_DEPTH - fifo_q.size()) >= COMMIT_W);
  endfunction

  function automatic bit exp_step();
    return (m_state == 1) && (fifo_q.size() > int'(m_out));
  endfunction

  task automatic model_reset();
    fifo_q.delete();
    m_state = 0; m_idle = 0; m_code = 0; m_mpc = 0; m_cnt = 0; m_out = 0; m_inc = 0;
  endtask

  task automatic model_fail(input int code);
    m_state = 2; m_inc = 1; m_code = code;
  endtask

  task automatic model_update();
    int  sz = fifo_q.size();
    bit  rdy = exp_ready();
    bit  stp = exp_step();
    int  np = $countones(dut_commit_valid);
    bit  contig = (int'(dut_commit_valid) == ((1 << np) - 1));
    bit  pe, mm;
    int  idle;
    rec_t r;
    if (m_state == 0) begin
      if (init_same) m_state = 1;
      else model_fail(1);
    end else if (m_state == 1) begin
      pe   = ((np != 0) && (!rdy || !contig)) || (ref_valid != m_out);
      mm   = ref_valid && m_out && !rec_eq(fifo_q[0]);
      idle = ((np == 0) && (sz == 0)) ? m_idle + 1 : 0;
      if (pe) model_fail(3);
      else if (mm) begin
        model_fail(2);
        m_mpc = int'(fifo_q[0].pc);
      end else if (idle == TIMEOUT) model_fail(4);
      else begin
        if (ref_valid) begin
          void'(fifo_q.pop_front());
          if (m_cnt != (1 << CNT_W) - 1) m_cnt++;
        end
        for (int i = 0; i < np; i++) begin
          r.pc    = dut_commit_pc[i*PC_W +: PC_W];
          r.rd    = dut_commit_rd[i*RD_W +: RD_W];
          r.wen   = dut_commit_wen[i];
          r.wdata = dut_commit_wdata[i*DATA_W +: DATA_W];
          fifo_q.push_back(r);
        end
        m_out  = stp;
        m_idle = idle;
      end
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_incorrect"}, incorrect, m_inc);
    chk({tag, "_fail_code"}, fail_code, m_code);
    chk({tag, "_mismatch_pc"}, mismatch_pc, m_mpc);
    chk({tag, "_match_count"}, match_count, m_cnt);
  endtask

  // ISA side: return the in-flight record one cycle after it was stepped.
  task automatic isa_drive();
    if ((m_state == 1) && m_out) begin
      ref_valid = 1'b1;
      ref_pc    = fifo_q[0].pc;
      ref_wen   = fifo_q[0].wen;
      ref_rd    = fifo_q[0].wen ? fifo_q[0].rd : RD_W'($urandom);
      ref_wdata = fifo_q[0].wen ? fifo_q[0].wdata : DATA_W'($urandom);
    end else begin
      ref_valid = 1'b0;
      ref_pc    = PC_W'($urandom);
      ref_rd    = RD_W'($urandom);
      ref_wen   = 1'($urandom);
      ref_wdata = DATA_W'($urandom);
    end
  endtask

  task automatic tick(input string tag);
    #1;
    chk({tag, "_dut_ready"}, dut_ready, exp_ready());
    chk({tag, "_ref_step"}, ref_step, exp_step());
    @(posedge clk);
    model_update();
    #1;
    check_regs(tag);
    dut_commit_valid = '0;
    isa_drive();
  endtask

  task automatic set_lane(input int i, input int pc, input int rd, input bit wen, input int wd);
    dut_commit_valid[i]                 = 1'b1;
    dut_commit_pc[i*PC_W +: PC_W]       = PC_W'(pc);
    dut_commit_rd[i*RD_W +: RD_W]       = RD_W'(rd);
    dut_commit_wen[i]                   = wen;
    dut_commit_wdata[i*DATA_W +: DATA_W] = DATA_W'(wd);
  endtask

  task automatic do_reset(input bit init_val, input string tag);
    rst = 1'b1;
    init_same = init_val;
    dut_commit_valid = '0;
    ref_valid = 1'b0;
    model_reset();
    #1;
    check_regs({tag, "_rst_async"});
    chk({tag, "_rst_ready"}, dut_ready, 1'b0);
    chk({tag, "_rst_step"}, ref_step, 1'b0);
    @(posedge clk);
    #1;
    check_regs({tag, "_rst"});
    rst = 1'b0;
  endtask

  initial begin
    // Init check failure: INIT sees init_same=0.
    do_reset(1'b0, "t1");
    tick("t1_init");
    chk("t1_code", fail_code, 3'b001);
    for (int i = 0; i < 4; i++) tick("t1_hold");

    // Two-lane group matched by the ISA on consecutive steps.
    do_reset(1'b1, "t2");
    tick("t2_init");
    set_lane(0, 0, 1, 1'b1, 5);
    set_lane(1, 1, 2, 1'b1, 7);
    tick("t2_push");
    chk("t2_step_a", ref_step, 1'b1);
    tick("t2_s1");
    chk("t2_step_b", ref_step, 1'b1);
    tick("t2_s2");
    tick("t2_s3");
    chk("t2_count", match_count, 16'd2);

    // Fill the buffer, then push while not ready.
    do_reset(1'b1, "t3");
    tick("t3_init");
    set_lane(0, 1, 0, 1'b1, 1); set_lane(1, 2, 0, 1'b1, 2);
    tick("t3_p1");
    set_lane(0, 3, 0, 1'b1, 3); set_lane(1, 4, 0, 1'b1, 4);
    tick("t3_p2");
    chk("t3_full_ready", dut_ready, 1'b0);
    set_lane(0, 5, 0, 1'b1, 5);
    tick("t3_over");
    chk("t3_code", fail_code, 3'b011);

    // Data mismatch on the second record after one good match.
    do_reset(1'b1, "t4");
    tick("t4_init");
    set_lane(0, 1, 0, 1'b1, 9); set_lane(1, 2, 1, 1'b1, 3);
    tick("t4_push");
    tick("t4_s1");
    tick("t4_s2");
    ref_wdata = 8'd4;
    tick("t4_bad");
    chk("t4_code", fail_code, 3'b010);
    chk("t4_mpc", mismatch_pc, 3'd2);
    chk("t4_count", match_count, 16'd1);
    tick("t4_hold1");
    tick("t4_hold2");

    // Non-contiguous lanes.
    do_reset(1'b1, "t5");
    tick("t5_init");
    set_lane(1, 6, 3, 1'b1, 8);
    tick("t5_gap");
    chk("t5_code", fail_code, 3'b011);

    // ISA result without a preceding step.
    do_reset(1'b1, "t6");
    tick("t6_init");
    ref_valid = 1'b1;
    tick("t6_spur");
    chk("t6_code", fail_code, 3'b011);

    // Watchdog fires on the 16th idle RUN cycle.
    do_reset(1'b1, "t7");
    tick("t7_init");
    for (int i = 0; i < TIMEOUT - 1; i++) tick("t7_idle");
    chk("t7_before", incorrect, 1'b0);
    tick("t7_last");
    chk("t7_code", fail_code, 3'b100);

    // Randomized traffic with a matching ISA, then reset mid-run.
    do_reset(1'b1, "t8");
    tick("t8_init");
    for (int c = 0; c < 400; c++) begin
      if (exp_ready() && ($urandom_range(0, 2) != 0)) begin
        set_lane(0, $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1)
          set_lane(1, $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 255));
      end
      tick("t8_rand");
    end
    chk("t8_progress", (match_count > 16'd100), 1'b1);
    do_reset(1'b1, "t9");
    chk("t9_count_zero", match_count, 16'd0);
    tick("t9_init");
    tick("t9_empty");
    chk("t9_no_step", ref_step, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
